// File: rtl/median_frame_ctrl_if.sv
// Pixel-stream bundle around the frame controller: upstream input, push port
// toward the 1x3 median filter (plus its registered result) and downstream output.
interface median_frame_ctrl_if;
  logic       s_vld, s_rdy, s_sof;
  logic [7:0] s_pix;
  logic       f_vld;
  logic [7:0] f_pix, f_res;
  logic       m_vld, m_sof, m_eol, m_eof;
  logic [7:0] m_pix;

  modport slave (
    input  s_vld, s_sof, s_pix, f_res,
    output s_rdy, f_vld, f_pix, m_vld, m_sof, m_eol, m_eof, m_pix
  );
  modport master (
    output s_vld, s_sof, s_pix, f_res,
    input  s_rdy, f_vld, f_pix, m_vld, m_sof, m_eol, m_eof, m_pix
  );
endinterface

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for an external 1x3 median filter: primes each line with a
// replicated first pixel, flushes with a replicated last pixel, tags frame flags.
module median_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_en,
  median_frame_ctrl_if.slave   io,
  output logic                 frame_done,
  output logic                 err_sof
);
  typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, LSTART, DONE} state_t;

  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [9:0]  Y_LAST = 10'(IMG_H - 1);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        en_q, en_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [7:0]  last_q, raw_q;
  logic        m_vld_q, m_sof_q, m_eol_q, m_eof_q;
  logic        rdy, push, emit, first, eol, start;
  logic [7:0]  push_pix;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    en_d     = en_q;
    err_d    = err_q;
    done_d   = 1'b0;
    rdy      = 1'b0;
    push     = 1'b0;
    push_pix = 8'd0;
    emit     = 1'b0;
    first    = 1'b0;
    eol      = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (io.s_vld && io.s_sof) start = 1'b1;
      end
      PRIME: begin
        // last_q still holds the line's first pixel, giving history p0,p0
        push     = 1'b1;
        push_pix = last_q;
        x_d      = 11'd1;
        state_d  = RUN;
      end
      RUN: begin
        rdy = 1'b1;
        if (io.s_vld) begin
          if (io.s_sof) begin
            start = 1'b1;
            err_d = 1'b1;
          end else begin
            push     = 1'b1;
            push_pix = io.s_pix;
            emit     = 1'b1;
            first    = (x_q == 11'd1) && (y_q == 10'd0);
            if (x_q == X_LAST) state_d = FLUSH;
            else               x_d     = x_q + 11'd1;
          end
        end
      end
      FLUSH: begin
        push     = 1'b1;
        push_pix = last_q;
        emit     = 1'b1;
        eol      = 1'b1;
        if (y_q == Y_LAST) state_d = DONE;
        else begin
          y_d     = y_q + 10'd1;
          x_d     = 11'd0;
          state_d = LSTART;
        end
      end
      LSTART: begin
        rdy = 1'b1;
        if (io.s_vld) begin
          if (io.s_sof) begin
            start = 1'b1;
            err_d = 1'b1;
          end else begin
            push     = 1'b1;
            push_pix = io.s_pix;
            state_d  = PRIME;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new frame start (clean or aborting) never produces an output itself
    if (start) begin
      push     = 1'b1;
      push_pix = io.s_pix;
      en_d     = cfg_en;
      x_d      = 11'd0;
      y_d      = 10'd0;
      state_d  = PRIME;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 11'd0;
      y_q     <= 10'd0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 8'd0;
      raw_q   <= 8'd0;
      m_vld_q <= 1'b0;
      m_sof_q <= 1'b0;
      m_eol_q <= 1'b0;
      m_eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      en_q    <= en_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (push) last_q <= push_pix;
      // Raw column k is the pixel pushed just before column k+1 (or the flush)
      if (emit) raw_q <= last_q;
      m_vld_q <= emit;
      m_sof_q <= emit & first;
      m_eol_q <= emit & eol;
      m_eof_q <= emit & eol & (y_q == Y_LAST);
    end
  end

  assign io.s_rdy   = rdy;
  assign io.f_vld   = push;
  assign io.f_pix   = push_pix;
  assign io.m_vld   = m_vld_q;
  assign io.m_sof   = m_sof_q;
  assign io.m_eol   = m_eol_q;
  assign io.m_eof   = m_eof_q;
  assign io.m_pix   = m_vld_q ? (en_q ? io.f_res : raw_q) : 8'd0;
  assign frame_done = done_q;
  assign err_sof    = err_q;
endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl with a behavioural 1x3 median filter attached.
module tb_median_frame_ctrl;
  localparam int W = 4;
  localparam int H = 2;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof, eol, eof;
  } orec_t;

  logic clk = 1'b0, rst_n = 1'b0, cfg_en = 1'b0;
  logic frame_done, err_sof;
  median_frame_ctrl_if io();

  median_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .io(io.slave),
    .frame_done(frame_done), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] med3(input logic [7:0] a, b, c);
    logic [7:0] q[$];
    q = {a, b, c};
    q.sort();
    return q[1];
  endfunction

  // Filter: 3-deep history of pushes, result registered one cycle after the push
  logic [7:0] h0 = 8'd0, h1 = 8'd0;
  always @(posedge clk)
    if (io.f_vld) begin
      io.f_res <= med3(h1, h0, io.f_pix);
      h1 <= h0;
      h0 <= io.f_pix;
    end

  int total = 0, bad = 0;
  int cyc = 0, eof_cyc = -1, done_cyc = -1, ndone = 0, rdy_lo = 0;
  orec_t      got_q[$], exp_q[$];
  logic [7:0] gotf_q[$], expf_q[$];
  logic [7:0] px[H][W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (rst_n) begin
      if (io.m_vld) begin
        got_q.push_back({io.m_pix, io.m_sof, io.m_eol, io.m_eof});
        if (io.m_eof) eof_cyc = cyc;
      end else
        chk("quiet_out", {io.m_sof, io.m_eol, io.m_eof, io.m_pix}, 32'd0);
      if (io.f_vld) gotf_q.push_back(io.f_pix);
      if (frame_done) begin ndone++; done_cyc = cyc; end
      if (!io.s_rdy) rdy_lo++;
    end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input bit sof, input logic [7:0] pix);
    bit acc = 1'b0;
    int n = 0;
    io.s_vld = 1'b1; io.s_sof = sof; io.s_pix = pix;
    while (!acc && n < 20) begin
      @(negedge clk); acc = io.s_rdy;
      @(posedge clk); #1; n++;
    end
    chk("accept", 32'(acc), 32'd1);
    io.s_vld = 1'b0; io.s_sof = 1'b0;
  endtask

  // Reference: a line of n sent pixels (n<W means aborted by a new s_sof)
  task automatic model_line(input int l, input int n, input bit en, input bit islast);
    int nout;
    orec_t r;
    if (n >= 1) begin expf_q.push_back(px[l][0]); expf_q.push_back(px[l][0]); end
    for (int k = 1; k < n; k++) expf_q.push_back(px[l][k]);
    if (n == W) expf_q.push_back(px[l][W-1]);
    nout = (n == W) ? W : n - 1;
    for (int k = 0; k < nout; k++) begin
      r.pix = en ? med3(px[l][(k > 0) ? k-1 : 0], px[l][k], px[l][(k < W-1) ? k+1 : W-1])
                 : px[l][k];
      r.sof = (l == 0) && (k == 0);
      r.eol = (k == W-1);
      r.eof = r.eol && islast;
      exp_q.push_back(r);
    end
  endtask

  task automatic send_frame(input bit en, input int gap, input int abort_at);
    cfg_en = en;
    for (int l = 0; l < H; l++) begin
      for (int k = 0; k < W; k++) begin
        if (l == 0 && k == abort_at) begin
          model_line(0, k, en, 1'b0);
          return;
        end
        drive(l == 0 && k == 0, px[l][k]);
        if (l == 0 && k == 0) cfg_en = ~en;
        if (gap == 1) step(1);
        else if (gap == 2) step($urandom_range(0, 2));
      end
      model_line(l, W, en, l == H-1);
    end
  endtask

  task automatic clear_obs();
    got_q.delete(); gotf_q.delete(); exp_q.delete(); expf_q.delete();
    ndone = 0; rdy_lo = 0; eof_cyc = -1; done_cyc = -1;
  endtask

  task automatic check(input string tag);
    step(8);
    chk({tag, "_nout"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_out"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_npush"}, gotf_q.size(), expf_q.size());
    for (int i = 0; i < gotf_q.size() && i < expf_q.size(); i++)
      chk({tag, "_push"}, 32'(gotf_q[i]), 32'(expf_q[i]));
  endtask

  task automatic fill_rand();
    for (int l = 0; l < H; l++)
      for (int k = 0; k < W; k++) px[l][k] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [7:0] ref_f[6];
    logic [7:0] ref_m[4];
    logic [7:0] ref_r[4];
    int t0, span_en;
    ref_f = '{8'd10, 8'd10, 8'd50, 8'd20, 8'd30, 8'd30};
    ref_m = '{8'd10, 8'd20, 8'd30, 8'd30};
    ref_r = '{8'd10, 8'd50, 8'd20, 8'd30};
    io.s_vld = 1'b0; io.s_sof = 1'b0; io.s_pix = 8'd0;
    step(2);
    @(negedge clk);
    chk("rst_rdy", 32'(io.s_rdy), 32'd1);
    chk("rst_outs", {io.f_vld, io.f_pix, io.m_vld, io.m_sof, io.m_eol, io.m_eof,
                     io.m_pix, frame_done, err_sof}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(2);

    // Directed line 10,50,20,30, filtered
    clear_obs();
    px[0] = '{8'd10, 8'd50, 8'd20, 8'd30};
    px[1] = '{8'd7, 8'd200, 8'd3, 8'd90};
    t0 = cyc;
    send_frame(1'b1, 0, W);
    step(8);
    span_en = eof_cyc - t0;
    for (int i = 0; i < 6; i++) if (i < gotf_q.size()) chk("dir_fpix", 32'(gotf_q[i]), 32'(ref_f[i]));
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("dir_mpix", 32'(got_q[i].pix), 32'(ref_m[i]));
    chk("dir_done_lag", done_cyc - eof_cyc, 32'd1);
    chk("dir_ndone", ndone, 32'd1);
    check("dir_en");

    // Same pixels in bypass
    clear_obs();
    t0 = cyc;
    send_frame(1'b0, 0, W);
    step(8);
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("byp_mpix", 32'(got_q[i].pix), 32'(ref_r[i]));
    chk("byp_timing", eof_cyc - t0, span_en);
    check("byp");

    // Toggling s_vld
    clear_obs();
    fill_rand();
    send_frame(1'($urandom_range(0, 1)), 1, W);
    check("toggle");
    chk("toggle_rdy_lo", rdy_lo, 2*H + 1);
    chk("toggle_ndone", ndone, 32'd1);

    for (int f = 0; f < 4; f++) begin
      clear_obs();
      fill_rand();
      send_frame(1'($urandom_range(0, 1)), 2, W);
      check("rand");
    end

    // Pixels without s_sof in IDLE are dropped
    clear_obs();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'($urandom_range(0, 255)));
    step(4);
    chk("junk_npush", gotf_q.size(), 32'd0);
    chk("junk_nout", got_q.size(), 32'd0);

    // Abort by s_sof at column 2 of line 0
    clear_obs();
    chk("err_pre", 32'(err_sof), 32'd0);
    fill_rand();
    send_frame(1'b1, 0, 2);
    fill_rand();
    send_frame(1'($urandom_range(0, 1)), 2, W);
    check("abort");
    chk("err_set", 32'(err_sof), 32'd1);
    step(5);
    chk("err_sticky", 32'(err_sof), 32'd1);

    // Reset mid-line
    fill_rand();
    drive(1'b1, px[0][0]);
    drive(1'b0, px[0][1]);
    rst_n = 1'b0;
    #1;
    chk("mrst_rdy", 32'(io.s_rdy), 32'd1);
    chk("mrst_outs", {io.f_vld, io.f_pix, io.m_vld, io.m_sof, io.m_eol, io.m_eof,
                      io.m_pix, frame_done, err_sof}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    clear_obs();
    fill_rand();
    send_frame(1'b1, 2, W);
    check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
